// File: rtl/otter_clk_en_gen.sv
// Clock-enable and reset-release generator for the OTTER pipeline.
// A run-control FSM gates a master tick; each channel divides that tick into a
// one-cycle CE strobe. RST_OUT is held for RST_HOLD cycles after RST releases.
module otter_clk_en_gen #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned DIV_W    = 16,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned BURST_W  = 16,
  parameter int unsigned RST_HOLD = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [1:0]              RUN_MODE,
  input  logic                    STEP,
  input  logic [BURST_W-1:0]      BURST_LEN,
  input  logic [NUM_CH*DIV_W-1:0] DIV,
  output logic [NUM_CH-1:0]       CE,
  output logic                    RST_OUT,
  output logic                    BUSY,
  output logic [CNT_W-1:0]        TICK_CNT
);

  localparam int unsigned HoldW = $clog2(RST_HOLD + 1);

  typedef enum logic [2:0] {StReset, StHalt, StRun, StStep, StBurst} state_e;

  state_e             state_q, state_d;
  logic [HoldW-1:0]   hold_q;
  logic [BURST_W-1:0] remain_q, remain_d;
  logic               step_q;
  logic               trigger;
  logic               tick;
  logic [CNT_W-1:0]   tick_cnt_q;
  logic [DIV_W-1:0]   cnt_q [NUM_CH];

  // Only a rising STEP edge counts; a held-high STEP yields one trigger.
  assign trigger = STEP & ~step_q;

  // State, hold counter, burst counter and STEP edge register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= StReset;
      hold_q   <= '0;
      remain_q <= '0;
      step_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      step_q   <= STEP;
      if (state_q == StReset && hold_q != HoldW'(RST_HOLD)) begin
        hold_q <= hold_q + HoldW'(1);
      end
    end
  end

  // Next-state: run-control decode. Triggers outside halt are simply dropped.
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    unique case (state_q)
      StReset: begin
        if (hold_q == HoldW'(RST_HOLD)) state_d = StHalt;
      end
      StHalt: begin
        case (RUN_MODE)
          2'b01: state_d = StRun;
          2'b10: if (trigger) state_d = StStep;
          2'b11: begin
            if (trigger && BURST_LEN != '0) begin
              state_d  = StBurst;
              remain_d = BURST_LEN;
            end
          end
          default: state_d = StHalt;
        endcase
      end
      StRun: begin
        if (RUN_MODE != 2'b01) state_d = StHalt;
      end
      StStep: state_d = StHalt;
      StBurst: begin
        // Burst ignores RUN_MODE; only RST can cut it short.
        if (remain_q == BURST_W'(1)) state_d = StHalt;
        else remain_d = remain_q - BURST_W'(1);
      end
      default: state_d = StReset;
    endcase
  end

  // Outputs decoded from registered state so they only move after CLK or RST.
  always_comb begin
    tick    = (state_q == StRun) || (state_q == StStep) || (state_q == StBurst);
    BUSY    = (state_q == StStep) || (state_q == StBurst);
    RST_OUT = (state_q == StReset);
  end

  // Per-channel CE: a ratio of 0 behaves as 1; a shrunk ratio fires at once.
  always_comb begin
    CE = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (DIV[i*DIV_W +: DIV_W] == '0) begin
        CE[i] = tick;
      end else begin
        CE[i] = tick & (cnt_q[i] >= (DIV[i*DIV_W +: DIV_W] - DIV_W'(1)));
      end
    end
  end

  // Channel counters advance only on master ticks.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else if (tick) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= CE[i] ? '0 : cnt_q[i] + DIV_W'(1);
      end
    end
  end

  // Master-tick counter, wraps naturally.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) tick_cnt_q <= '0;
    else if (tick) tick_cnt_q <= tick_cnt_q + CNT_W'(1);
  end

  assign TICK_CNT = tick_cnt_q;

endmodule

// File: tb/tb_otter_clk_en_gen.sv
// Directed bench for otter_clk_en_gen: cycle table for free-run/step/burst,
// plus hand sequences for reset stretch, async abort, divide shrink and wrap.
module tb_otter_clk_en_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  run_mode;
  logic [1:0]  run_mode_b;
  logic        step;
  logic [15:0] burst_len;
  logic [63:0] div;
  logic [3:0]  ce;
  logic [3:0]  ce_b;
  logic        rst_out, rst_out_b;
  logic        busy, busy_b;
  logic [31:0] tick_cnt;
  logic [7:0]  tick_cnt_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  otter_clk_en_gen dut (
    .CLK       (clk),
    .RST       (rst),
    .RUN_MODE  (run_mode),
    .STEP      (step),
    .BURST_LEN (burst_len),
    .DIV       (div),
    .CE        (ce),
    .RST_OUT   (rst_out),
    .BUSY      (busy),
    .TICK_CNT  (tick_cnt)
  );

  // Narrow tick counter instance for the wrap check.
  otter_clk_en_gen #(.CNT_W(8)) dut_b (
    .CLK       (clk),
    .RST       (rst),
    .RUN_MODE  (run_mode_b),
    .STEP      (step),
    .BURST_LEN (burst_len),
    .DIV       (div),
    .CE        (ce_b),
    .RST_OUT   (rst_out_b),
    .BUSY      (busy_b),
    .TICK_CNT  (tick_cnt_b)
  );

  typedef struct {
    logic [1:0]  mode;
    logic        step;
    logic [15:0] len;
    logic [3:0]  ce;
    logic        busy;
    logic [31:0] tc;
  } vec_t;

  vec_t vecs [29];

  function automatic vec_t mk(input logic [1:0] mode, input logic stp, input logic [15:0] len,
                              input logic [3:0] e_ce, input logic e_busy, input logic [31:0] e_tc);
    vec_t v;
    v.mode = mode;
    v.step = stp;
    v.len  = len;
    v.ce   = e_ce;
    v.busy = e_busy;
    v.tc   = e_tc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drop RST at a falling edge and watch the 8-cycle stretch.
  task automatic release_stretch(input string tag);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("%s rst_out k=%0d", tag, k), {31'b0, rst_out}, {31'b0, (k <= 8)});
      check($sformatf("%s ce k=%0d", tag, k), {28'b0, ce}, 32'd0);
      check($sformatf("%s tick_cnt k=%0d", tag, k), tick_cnt, 32'd0);
      check($sformatf("%s busy k=%0d", tag, k), {31'b0, busy}, 32'd0);
    end
  endtask

  initial begin
    // ce = {ch3, ch2, ch1, ch0}; ratios ch3..ch0 = {0,3,2,1}.
    for (int j = 0; j < 12; j++) vecs[j] = mk(2'b01, 1'b0, 16'd0, 4'b1001, 1'b0, 32'(j));
    vecs[1]  = mk(2'b01, 1'b0, 16'd0, 4'b1011, 1'b0, 32'd1);
    vecs[2]  = mk(2'b01, 1'b0, 16'd0, 4'b1101, 1'b0, 32'd2);
    vecs[3]  = mk(2'b01, 1'b0, 16'd0, 4'b1011, 1'b0, 32'd3);
    vecs[5]  = mk(2'b01, 1'b0, 16'd0, 4'b1111, 1'b0, 32'd5);
    vecs[7]  = mk(2'b01, 1'b0, 16'd0, 4'b1011, 1'b0, 32'd7);
    vecs[8]  = mk(2'b01, 1'b0, 16'd0, 4'b1101, 1'b0, 32'd8);
    vecs[9]  = mk(2'b01, 1'b0, 16'd0, 4'b1011, 1'b0, 32'd9);
    vecs[11] = mk(2'b01, 1'b0, 16'd0, 4'b1111, 1'b0, 32'd11);
    vecs[12] = mk(2'b00, 1'b0, 16'd0, 4'b0000, 1'b0, 32'd12);
    // Single step with STEP held, then a second pulse.
    vecs[13] = mk(2'b10, 1'b1, 16'd0, 4'b1001, 1'b1, 32'd12);
    vecs[14] = mk(2'b10, 1'b1, 16'd0, 4'b0000, 1'b0, 32'd13);
    vecs[15] = mk(2'b10, 1'b1, 16'd0, 4'b0000, 1'b0, 32'd13);
    vecs[16] = mk(2'b10, 1'b1, 16'd0, 4'b0000, 1'b0, 32'd13);
    vecs[17] = mk(2'b10, 1'b1, 16'd0, 4'b0000, 1'b0, 32'd13);
    vecs[18] = mk(2'b10, 1'b0, 16'd0, 4'b0000, 1'b0, 32'd13);
    vecs[19] = mk(2'b10, 1'b1, 16'd0, 4'b1011, 1'b1, 32'd13);
    vecs[20] = mk(2'b10, 1'b0, 16'd0, 4'b0000, 1'b0, 32'd14);
    // Burst of 5 with a mode change and a STEP pulse in the middle.
    vecs[21] = mk(2'b11, 1'b1, 16'd5, 4'b1101, 1'b1, 32'd14);
    vecs[22] = mk(2'b00, 1'b0, 16'd5, 4'b1011, 1'b1, 32'd15);
    vecs[23] = mk(2'b00, 1'b1, 16'd5, 4'b1001, 1'b1, 32'd16);
    vecs[24] = mk(2'b11, 1'b0, 16'd5, 4'b1111, 1'b1, 32'd17);
    vecs[25] = mk(2'b11, 1'b0, 16'd5, 4'b1001, 1'b1, 32'd18);
    vecs[26] = mk(2'b11, 1'b0, 16'd5, 4'b0000, 1'b0, 32'd19);
    // Zero-length burst trigger does nothing.
    vecs[27] = mk(2'b11, 1'b1, 16'd0, 4'b0000, 1'b0, 32'd19);
    vecs[28] = mk(2'b00, 1'b0, 16'd0, 4'b0000, 1'b0, 32'd19);

    rst        = 1'b1;
    step       = 1'b0;
    run_mode   = 2'b00;
    run_mode_b = 2'b00;
    burst_len  = 16'd0;
    div        = {16'd0, 16'd3, 16'd2, 16'd1};

    repeat (3) @(posedge clk);
    #1;
    check("reset rst_out", {31'b0, rst_out}, 32'd1);
    check("reset ce", {28'b0, ce}, 32'd0);
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset tick_cnt", tick_cnt, 32'd0);
    release_stretch("stretch1");

    for (int i = 0; i < 29; i++) begin
      @(negedge clk);
      run_mode  = vecs[i].mode;
      step      = vecs[i].step;
      burst_len = vecs[i].len;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d ce", i), {28'b0, ce}, {28'b0, vecs[i].ce});
      check($sformatf("vec%0d busy", i), {31'b0, busy}, {31'b0, vecs[i].busy});
      check($sformatf("vec%0d tick_cnt", i), tick_cnt, vecs[i].tc);
    end

    // Async reset on the third burst tick.
    @(negedge clk);
    run_mode  = 2'b11;
    burst_len = 16'd5;
    step      = 1'b1;
    @(negedge clk);
    step     = 1'b0;
    run_mode = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check("abort pre busy", {31'b0, busy}, 32'd1);
    check("abort pre tick_cnt", tick_cnt, 32'd21);
    #2;
    rst = 1'b1;
    #1;
    check("abort ce", {28'b0, ce}, 32'd0);
    check("abort busy", {31'b0, busy}, 32'd0);
    check("abort tick_cnt", tick_cnt, 32'd0);
    check("abort rst_out", {31'b0, rst_out}, 32'd1);
    repeat (2) @(posedge clk);
    release_stretch("stretch2");

    // Divide shrink on channel 2: ratio 10 for 7 ticks, then ratio 4.
    @(negedge clk);
    div[47:32] = 16'd10;
    run_mode   = 2'b01;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("shrink pre ce2 k=%0d", k), {31'b0, ce[2]}, 32'd0);
    end
    @(negedge clk);
    run_mode = 2'b00;
    @(posedge clk);
    #1;
    check("shrink halt ce", {28'b0, ce}, 32'd0);
    check("shrink halt tick_cnt", tick_cnt, 32'd7);
    @(negedge clk);
    div[47:32] = 16'd4;
    run_mode   = 2'b01;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("shrink post ce2 k=%0d", k), {31'b0, ce[2]},
            {31'b0, (k == 1 || k == 5 || k == 9)});
    end
    @(negedge clk);
    run_mode = 2'b00;

    // 260 ticks on the 8-bit counter wrap to 4.
    @(negedge clk);
    run_mode_b = 2'b01;
    repeat (260) @(posedge clk);
    @(negedge clk);
    run_mode_b = 2'b00;
    @(posedge clk);
    #1;
    check("wrap tick_cnt", {24'b0, tick_cnt_b}, 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
